// File: rtl/dda_pkg.sv
// dda_pkg: shared constants, frame byte map and link FSM encoding
// for the DDA host-side UART link.
package dda_pkg;

   localparam int N           = 16;
   localparam int PARAM_BYTES = 10;
   localparam int RESP_BYTES  = 5;

   localparam int IC1_HI = 0;
   localparam int IC1_LO = 1;
   localparam int IC2_HI = 2;
   localparam int IC2_LO = 3;
   localparam int VKM_HI = 4;
   localparam int VKM_LO = 5;
   localparam int VDM_HI = 6;
   localparam int VDM_LO = 7;
   localparam int DT_HI  = 8;
   localparam int DT_LO  = 9;

   localparam int BIDX_W = $clog2(PARAM_BYTES);
   localparam int RIDX_W = $clog2(RESP_BYTES + 1);
   localparam int SH_W   = 2 * N;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX_WAIT,
      S_TX_ACK,
      S_TX_DONE,
      S_RX
   } link_state_t;

endpackage

// File: rtl/dda_host_link_timeout.sv
// link_timeout: per-byte watchdog; counts enabled cycles since the
// last clear and flags the final count as expired.
module link_timeout #(
   parameter int TIMEOUT = 2000000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_expired = i_en && (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/dda_host_link.sv
// dda_host_link: sends the 10-byte parameter frame over a byte UART,
// collects the solver response and rebuilds v1/v2.
module dda_host_link
   import dda_pkg::*;
#(
   parameter int TIMEOUT = 2000000
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [N-1:0] i_ic1,
   input  logic [N-1:0] i_ic2,
   input  logic [N-1:0] i_vK_M,
   input  logic [N-1:0] i_vD_M,
   input  logic [N-1:0] i_dt,
   output logic         o_transmit,
   output logic [7:0]   o_tx_byte,
   input  logic         i_is_transmitting,
   input  logic         i_received,
   input  logic [7:0]   i_rx_byte,
   input  logic         i_recv_error,
   output logic [N-1:0] o_v1,
   output logic [N-1:0] o_v2,
   output logic         o_done,
   output logic         o_busy,
   output logic         o_err
);

   link_state_t r_state;
   link_state_t w_state_nxt;

   logic [7:0]        r_frame [PARAM_BYTES];
   logic [BIDX_W-1:0] r_byte_idx;
   logic [RIDX_W-1:0] r_rx_idx;
   logic [SH_W-1:0]   r_sh;
   logic [SH_W-1:0]   w_sh_nxt;
   logic              r_transmit;
   logic [7:0]        r_tx_byte;
   logic [N-1:0]      r_v1;
   logic [N-1:0]      r_v2;
   logic              r_done;
   logic              r_err;

   logic w_expired;
   logic w_to;
   logic w_tmr_en;
   logic w_tmr_clr;
   logic w_last_tx;
   logic w_last_rx;
   logic w_accept;
   logic w_send;
   logic w_tx_next;
   logic w_rx_take;
   logic w_abort;

   // An arriving byte outranks a same-cycle watchdog expiry.
   assign w_to      = w_expired && !i_received;
   assign w_last_tx = (r_byte_idx == BIDX_W'(PARAM_BYTES - 1));
   assign w_last_rx = (r_rx_idx == RIDX_W'(RESP_BYTES - 1));
   assign w_tmr_en  = (r_state == S_TX_ACK) || (r_state == S_TX_DONE) ||
                      (r_state == S_RX);
   assign w_tmr_clr = (w_state_nxt != r_state) || i_received;

   link_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (w_tmr_clr),
      .i_en      (w_tmr_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (i_start) w_state_nxt = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            if (!i_is_transmitting) w_state_nxt = S_TX_ACK;
         end
         S_TX_ACK: begin
            if (w_to) w_state_nxt = S_IDLE;
            else if (i_is_transmitting) w_state_nxt = S_TX_DONE;
         end
         S_TX_DONE: begin
            if (w_to) w_state_nxt = S_IDLE;
            else if (!i_is_transmitting)
               w_state_nxt = w_last_tx ? S_RX : S_TX_WAIT;
         end
         S_RX: begin
            if (i_recv_error || w_to) w_state_nxt = S_IDLE;
            else if (i_received && w_last_rx) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_accept  = 1'b0;
      w_send    = 1'b0;
      w_tx_next = 1'b0;
      w_rx_take = 1'b0;
      w_abort   = 1'b0;
      unique case (r_state)
         S_IDLE:    w_accept  = i_start;
         S_TX_WAIT: w_send    = !i_is_transmitting;
         S_TX_ACK:  w_abort   = w_to;
         S_TX_DONE: begin
            w_abort   = w_to;
            w_tx_next = !w_to && !i_is_transmitting;
         end
         S_RX: begin
            w_abort   = i_recv_error || w_to;
            w_rx_take = !i_recv_error && !w_to && i_received;
         end
         default: w_abort = 1'b0;
      endcase
   end

   // Only the first four response bytes carry state; later ones are dropped.
   assign w_sh_nxt = (r_rx_idx < RIDX_W'(SH_W / 8)) ?
                     {r_sh[SH_W-9:0], i_rx_byte} : r_sh;

   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_frame[IC1_HI] <= i_ic1[15:8];
         r_frame[IC1_LO] <= i_ic1[7:0];
         r_frame[IC2_HI] <= i_ic2[15:8];
         r_frame[IC2_LO] <= i_ic2[7:0];
         r_frame[VKM_HI] <= i_vK_M[15:8];
         r_frame[VKM_LO] <= i_vK_M[7:0];
         r_frame[VDM_HI] <= i_vD_M[15:8];
         r_frame[VDM_LO] <= i_vD_M[7:0];
         r_frame[DT_HI]  <= i_dt[15:8];
         r_frame[DT_LO]  <= i_dt[7:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_byte_idx <= '0;
         r_rx_idx   <= '0;
         r_sh       <= '0;
         r_transmit <= 1'b0;
         r_tx_byte  <= '0;
         r_v1       <= '0;
         r_v2       <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_transmit <= w_send;
         r_done     <= w_rx_take && w_last_rx;
         if (w_accept) begin
            r_err      <= 1'b0;
            r_byte_idx <= '0;
         end
         if (w_send) r_tx_byte <= r_frame[r_byte_idx];
         if (w_tx_next) begin
            r_byte_idx <= r_byte_idx + BIDX_W'(1);
            if (w_last_tx) r_rx_idx <= '0;
         end
         if (w_rx_take) begin
            r_sh     <= w_sh_nxt;
            r_rx_idx <= r_rx_idx + RIDX_W'(1);
            if (w_last_rx) begin
               r_v1 <= w_sh_nxt[SH_W-1:N];
               r_v2 <= w_sh_nxt[N-1:0];
            end
         end
         if (w_abort) r_err <= 1'b1;
      end
   end

   assign o_transmit = r_transmit;
   assign o_tx_byte  = r_tx_byte;
   assign o_v1       = r_v1;
   assign o_v2       = r_v2;
   assign o_done     = r_done;
   assign o_err      = r_err;
   assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_dda_host_link.sv
// tb_dda_host_link: directed bench with a small UART model for the
// DDA host link; short watchdog so aborts are quick to reach.
module tb_dda_host_link;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] ic1, ic2, vkm, vdm, dt;
   logic        transmit;
   logic [7:0]  tx_byte;
   logic        is_tx;
   logic        received;
   logic [7:0]  rx_byte;
   logic        recv_error;
   logic [15:0] v1, v2;
   logic        done;
   logic        busy;
   logic        err;

   int checks = 0;
   int failures = 0;

   logic       uart_en;
   int         busy_cnt;
   int         viol;
   int         done_cnt;
   logic [7:0] cap_q [$];

   logic [7:0] exp_a [10] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h38,
                              8'h00, 8'h30, 8'h00, 8'h20, 8'h00};
   logic [7:0] exp_b [10] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A,
                              8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'h1E};

   dda_host_link #(
      .TIMEOUT (50)
   ) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_start           (start),
      .i_ic1             (ic1),
      .i_ic2             (ic2),
      .i_vK_M            (vkm),
      .i_vD_M            (vdm),
      .i_dt              (dt),
      .o_transmit        (transmit),
      .o_tx_byte         (tx_byte),
      .i_is_transmitting (is_tx),
      .i_received        (received),
      .i_rx_byte         (rx_byte),
      .i_recv_error      (recv_error),
      .o_v1              (v1),
      .o_v2              (v2),
      .o_done            (done),
      .o_busy            (busy),
      .o_err             (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // UART model: busy for 3 cycles per accepted byte when enabled.
   assign is_tx = (busy_cnt != 0);

   always @(posedge clk) begin
      if (rst) begin
         busy_cnt <= 0;
      end else begin
         if (transmit) begin
            cap_q.push_back(tx_byte);
            if (is_tx) viol <= viol + 1;
         end
         if (transmit && uart_en) busy_cnt <= 3;
         else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic set_a();
      ic1 = 16'h4000; ic2 = 16'h0000; vkm = 16'h3800;
      vdm = 16'h3000; dt = 16'h2000;
   endtask

   task automatic set_b();
      ic1 = 16'h1234; ic2 = 16'h5678; vkm = 16'h9ABC;
      vdm = 16'hDEF0; dt = 16'h0F1E;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_byte = b;
      received = 1'b1;
      tick(1);
      received = 1'b0;
   endtask

   task automatic wait_frame(input int nbytes);
      int n;
      n = 0;
      while (cap_q.size() < nbytes && n < 400) begin
         tick(1);
         n++;
      end
      chk("frame_len", cap_q.size(), nbytes);
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; received = 1'b0; rx_byte = '0;
      recv_error = 1'b0; uart_en = 1'b1; viol = 0; done_cnt = 0;
      set_a();
      tick(3);
      chk("rst_transmit", transmit, 0);
      chk("rst_txbyte", tx_byte, 0);
      chk("rst_v1v2", {v1, v2}, 0);
      chk("rst_flags", {done, busy, err}, 0);
      rst = 1'b0;
      tick(2);

      // Exchange 1: frame A with a mid-frame start and stray bytes.
      pulse_start();
      chk("lat_busy", {busy, transmit}, 2'b10);
      tick(1);
      chk("lat_transmit", transmit, 1);
      for (int i = 0; i < 30; i++) begin
         if (i == 5) begin
            set_b();
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (i == 9 || i == 22) begin
            rx_byte = 8'h55;
            received = 1'b1;
         end else begin
            received = 1'b0;
         end
         tick(1);
      end
      start = 1'b0; received = 1'b0;
      wait_frame(10);
      tick(8);
      chk("frame_a_count", cap_q.size(), 10);
      for (int i = 0; i < 10; i++)
         chk($sformatf("frame_a_%0d", i), cap_q[i], exp_a[i]);
      chk("tx_while_busy", viol, 0);
      send_rx(8'h3F); tick(2);
      send_rx(8'h80); tick(2);
      send_rx(8'hC1); tick(2);
      send_rx(8'h20); tick(2);
      chk("no_early_done", {done_cnt, 16'h0, v1}, 0);
      send_rx(8'hAA);
      chk("done_pulse", done, 1);
      chk("resp_v1", v1, 16'h3F80);
      chk("resp_v2", v2, 16'hC120);
      tick(1);
      chk("after_done", {done, busy, err}, 0);
      chk("done_count", done_cnt, 1);

      // Exchange 2: UART never accepts, watchdog aborts in TX_ACK.
      cap_q.delete();
      uart_en = 1'b0;
      set_a();
      pulse_start();
      n = 0;
      while (!transmit && n < 10) begin
         tick(1);
         n++;
      end
      chk("to_first_pulse", transmit, 1);
      n = 0;
      while (!err && n < 200) begin
         tick(1);
         n++;
      end
      chk("to_cycles", n, 50);
      chk("to_state", {err, busy, done}, 3'b100);
      chk("to_hold_v", {v1, v2}, 32'h3F80C120);
      chk("to_pulses", cap_q.size(), 1);
      tick(2);
      chk("to_no_done", done_cnt, 1);

      // Exchange 3: new start clears err, then recv_error in RX.
      cap_q.delete();
      uart_en = 1'b1;
      set_b();
      pulse_start();
      chk("err_cleared", {err, busy}, 2'b01);
      wait_frame(10);
      tick(8);
      for (int i = 0; i < 10; i++)
         chk($sformatf("frame_b_%0d", i), cap_q[i], exp_b[i]);
      send_rx(8'h11); tick(2);
      send_rx(8'h22); tick(2);
      recv_error = 1'b1;
      tick(1);
      recv_error = 1'b0;
      chk("rxerr_state", {err, busy, done}, 3'b100);
      chk("rxerr_hold_v", {v1, v2}, 32'h3F80C120);
      tick(2);
      chk("rxerr_no_done", done_cnt, 1);

      // Exchange 4: reset during the fourth byte, then a clean frame.
      cap_q.delete();
      set_a();
      pulse_start();
      wait_frame(4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("midrst_flags", {busy, transmit, err, done}, 0);
      chk("midrst_v", {v1, v2}, 0);
      tick(2);
      cap_q.delete();
      pulse_start();
      wait_frame(10);
      for (int i = 0; i < 10; i++)
         chk($sformatf("frame_r_%0d", i), cap_q[i], exp_a[i]);
      chk("tx_while_busy_all", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dda_host_link.md
Name: dda_host_link

Overview:
- Host-side initiator for the DDA solver's UART byte protocol; the counterpart of the on-chip responder.
- On `start` it snapshots five 16-bit parameters and sends them as a 10-byte big-endian frame through a byte-level UART transmitter handshake.
- It then collects the solver's response bytes, rebuilds v1/v2, and pulses `done`.
- It sits between a byte UART (`transmit`/`is_transmitting`, `received`/`rx_byte`) and a test/host controller.

Parameters:
- N, 16, posit word width; parameter and state words are N bits, sent as N/8 bytes MSB first.
- PARAM_BYTES, 10, bytes per outgoing frame (ic1, ic2, vK_M, vD_M, dt).
- RESP_BYTES, 5, bytes returned per exchange; bytes 0..3 are state, any later bytes are read and discarded.
- TIMEOUT, 2000000, idle clock cycles allowed per byte (tx completion or rx arrival) before abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin exchange; sampled only in IDLE
- ic1, ic2, vK_M, vD_M, dt  in  N each  parameters; captured on accepted start
- transmit  out  1  one-cycle pulse requesting UART send of tx_byte
- tx_byte  out  8  byte to send; held stable from pulse until the next pulse
- is_transmitting  in  1  UART busy flag
- received  in  1  one-cycle pulse: rx_byte valid
- rx_byte  in  8  received byte
- recv_error  in  1  UART framing error pulse
- v1, v2  out  N  reconstructed state; updated only on done
- done  out  1  one-cycle pulse, exchange complete
- busy  out  1  high in every state except IDLE
- err  out  1  sticky abort flag; cleared on the next accepted start

Behaviour:
- Reset values: transmit=0, tx_byte=0, v1=0, v2=0, done=0, busy=0, err=0; state=IDLE; all counters 0.
- IDLE:
  - `start` → capture all five words into a frame register; clear err; byte_idx=0; go to TX_WAIT.
  - Frame byte order: ic1[15:8], ic1[7:0], ic2 hi, ic2 lo, vK_M hi/lo, vD_M hi/lo, dt hi/lo.
- TX_WAIT:
  - When is_transmitting=0: drive tx_byte=frame[byte_idx] and pulse transmit for one cycle; go to TX_ACK.
- TX_ACK:
  - Wait for is_transmitting=1 (acceptance), then go to TX_DONE.
- TX_DONE:
  - Wait for is_transmitting=0, then byte_idx+1.
  - If byte_idx was PARAM_BYTES-1, set rx_idx=0 and go to RX; else go to TX_WAIT.
- RX:
  - Each `received` pulse: if rx_idx<4, shift rx_byte into shadow register sh[31:0] MSB first; rx_idx+1.
  - On the RESP_BYTES-th byte: v1=sh[31:16], v2=sh[15:0] (including the byte just received when RESP_BYTES==4); pulse done; go to IDLE.
- Timeout counter:
  - Reset to 0 on every state change and on every `received` pulse; increments in TX_ACK, TX_DONE and RX.
  - Reaching TIMEOUT-1 → err=1, transmit=0, go to IDLE. v1/v2 keep their previous values; done is not pulsed.
- recv_error in RX: same abort as timeout. recv_error outside RX is ignored.
- `received` outside RX is ignored; no bytes are buffered.
- `start` while busy is ignored. Parameter inputs may change freely after capture.
- Simultaneous `received` and timeout expiry in the same cycle: the byte wins and the counter resets.
- Reset mid-exchange: immediate return to IDLE with all outputs at reset values. Frame contents are not required to be cleared.
- `done` and `busy`: done fires in the same cycle the state returns to IDLE, so busy=0 in the cycle after done.
- Latency: start → first transmit pulse = 2 cycles if the UART is idle.

Decomposition:
- Shared package `dda_pkg`:
  - Constants N, PARAM_BYTES, RESP_BYTES.
  - Byte-index localparams for the frame fields (IC1_HI=0 … DT_LO=9).
  - State encoding: IDLE, TX_WAIT, TX_ACK, TX_DONE, RX.
- One sub-module, `link_timeout`: a counter with clear/enable/expired outputs, width $clog2(TIMEOUT). Everything else stays inline.

Test Plan:
- UART model (busy for 3 cycles per byte): start with ic1=16'h4000, ic2=16'h0000, vK_M=16'h3800, vD_M=16'h3000, dt=16'h2000 → exactly 10 transmit pulses carrying 40 00 00 00 38 00 30 00 20 00, in order, each issued only while is_transmitting=0.
- After the frame, inject received bytes 3F 80 C1 20 AA → done pulses once on the 5th byte; v1=16'h3F80, v2=16'hC120; AA is discarded; busy drops the next cycle.
- UART model never raises is_transmitting after a pulse (TIMEOUT=50) → err=1 after 50 cycles in TX_ACK; no done; v1/v2 unchanged; the next start clears err.
- Inject recv_error after 2 response bytes → err=1, IDLE, v1/v2 hold prior values.
- Assert start again mid-frame and inject stray `received` pulses during TX → frame unaffected, no extra pulses, no extra response bytes captured.
- Assert rst during byte 4 of TX → next cycle: busy=0, transmit=0, err=0, v1=v2=0; a fresh start sends the full 10-byte frame from byte 0.
